// File: rtl/cache_controller.sv
// Two-way set-associative, write-back, write-allocate cache controller.
// It owns the tag/valid/dirty/LRU state and sequences hit service, victim write-back and line fill.
module cache_controller #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int RAM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              wren,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              ack,
  output logic              hit,
  output logic [DATA_W-1:0] cache_out,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_out,
  output logic [7:0]        hit_count,
  output logic [7:0]        miss_count,
  output logic [2:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - 2;

  // Handshake: a request is accepted on a rising edge where req=1 and ready=1;
  // ack pulses for exactly one cycle per accepted request, req outside IDLE is dropped.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COMPARE   = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL_WAIT = 3'd3,
    S_FILL      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_wren;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_valid [4];
  logic [1:0]        r_dirty [4];
  logic [3:0]        r_lru;
  logic [TAG_W-1:0]  r_tag  [4][2];
  logic [DATA_W-1:0] r_line [4][2];
  logic              r_victim;
  logic [1:0]        r_cnt;
  logic              r_hit;
  logic [DATA_W-1:0] r_cache_out;
  logic [7:0]        r_hit_count;
  logic [7:0]        r_miss_count;

  logic [1:0]        w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit0;
  logic              w_hit1;
  logic              w_is_hit;
  logic              w_hit_way;
  logic              w_miss_victim;
  logic              w_victim_dirty;
  logic              w_fill_last;

  assign w_idx     = r_addr[1:0];
  assign w_tag     = r_addr[ADDR_W-1:2];
  assign w_hit0    = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
  assign w_hit1    = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
  assign w_is_hit  = w_hit0 || w_hit1;
  assign w_hit_way = !w_hit0;

  // Victim: first invalid way (way0 first), otherwise the way the LRU bit names.
  assign w_miss_victim  = !r_valid[w_idx][0] ? 1'b0 :
                          !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];
  assign w_victim_dirty = r_valid[w_idx][w_miss_victim] && r_dirty[w_idx][w_miss_victim];
  assign w_fill_last    = (r_cnt == 2'(RAM_LAT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (req) w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_is_hit)            w_next = S_DONE;
        else if (w_victim_dirty) w_next = S_WRITEBACK;
        else                     w_next = S_FILL_WAIT;
      end
      S_WRITEBACK: w_next = S_FILL_WAIT;
      S_FILL_WAIT: if (w_fill_last) w_next = S_FILL;
      S_FILL:      w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ram_wren    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    case (r_state)
      S_WRITEBACK: begin
        ram_wren    = 1'b1;
        ram_address = {r_tag[w_idx][r_victim], w_idx};
        ram_data    = r_line[w_idx][r_victim];
      end
      // Address is held through FILL so the read data is still valid when captured.
      S_FILL_WAIT, S_FILL: ram_address = r_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wren       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lru        <= '0;
      r_victim     <= 1'b0;
      r_cnt        <= '0;
      r_hit        <= 1'b0;
      r_cache_out  <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
      for (int i = 0; i < 4; i++) begin
        r_valid[i] <= '0;
        r_dirty[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_wren  <= wren;
            r_addr  <= address;
            r_wdata <= data;
          end
        end
        S_COMPARE: begin
          r_cnt <= '0;
          if (w_is_hit) begin
            r_hit <= 1'b1;
            if (r_wren) r_dirty[w_idx][w_hit_way] <= 1'b1;
            else        r_cache_out <= r_line[w_idx][w_hit_way];
            r_lru[w_idx] <= !w_hit_way;
          end else begin
            r_hit    <= 1'b0;
            r_victim <= w_miss_victim;
          end
        end
        S_WRITEBACK: r_cnt <= '0;
        S_FILL_WAIT: r_cnt <= r_cnt + 2'd1;
        S_FILL: begin
          r_valid[w_idx][r_victim] <= 1'b1;
          r_dirty[w_idx][r_victim] <= r_wren;
          if (!r_wren) r_cache_out <= ram_out;
          r_lru[w_idx] <= !r_victim;
        end
        S_DONE: begin
          if (r_hit) begin
            if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
          end else begin
            if (r_miss_count != 8'hFF) r_miss_count <= r_miss_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (r_state == S_COMPARE && w_is_hit && r_wren)
      r_line[w_idx][w_hit_way] <= r_wdata;
    if (r_state == S_FILL) begin
      r_tag[w_idx][r_victim]  <= w_tag;
      r_line[w_idx][r_victim] <= r_wren ? r_wdata : ram_out;
    end
  end

  assign ready      = (r_state == S_IDLE);
  assign ack        = (r_state == S_DONE);
  assign hit        = r_hit;
  assign cache_out  = r_cache_out;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: driver tasks issue accesses and push expected
// responses; a monitor pops and compares on every ack. Includes a latency-modelled RAM.
module tb_cache_controller;

  logic       clock;
  logic       reset;
  logic       req;
  logic       wren;
  logic [7:0] address;
  logic [7:0] data;
  logic       ready;
  logic       ack;
  logic       hit;
  logic [7:0] cache_out;
  logic [7:0] ram_address;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [7:0] ram_out;
  logic [7:0] hit_count;
  logic [7:0] miss_count;
  logic [2:0] dbg_state;

  cache_controller #(.ADDR_W(8), .DATA_W(8), .RAM_LAT(2)) dut (
    .clock(clock), .reset(reset), .req(req), .wren(wren), .address(address),
    .data(data), .ready(ready), .ack(ack), .hit(hit), .cache_out(cache_out),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_out(ram_out), .hit_count(hit_count), .miss_count(miss_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  // ---------------- RAM model (2-cycle read latency) ----------------
  logic [7:0] mem [256];
  logic [7:0] addr_pipe [2];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i + 16);
  always @(posedge clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    addr_pipe[0] <= ram_address;
    addr_pipe[1] <= addr_pipe[0];
  end
  assign ram_out = mem[addr_pipe[1]];

  // ---------------- scoreboard ----------------
  // entry = {check_data, exp_hit, exp_data[7:0], exp_latency[3:0]}
  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int wr_cnt = 0;
  int req_cycle = 0;
  logic prev_wren = 1'b0;
  logic prev_ack = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    logic [13:0] e;
    int lat;
    if (reset) begin
      prev_wren = 1'b0;
      prev_ack  = 1'b0;
    end else begin
      if (ram_wren) begin
        wr_cnt++;
        check("ram_wren_single_cycle", int'(prev_wren), 0);
      end
      prev_wren = ram_wren;
      if (ack) begin
        ack_cnt++;
        check("ack_single_cycle", int'(prev_ack), 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack got=1 expected=0 (t=%0t)", $time);
        end else begin
          e   = exp_q.pop_front();
          lat = cycle - req_cycle;
          check("hit_flag", int'(hit), int'(e[12]));
          if (e[13]) check("cache_out", int'(cache_out), int'(e[11:4]));
          check("ack_latency", lat, int'(e[3:0]));
        end
      end
      prev_ack = ack;
    end
  end

  // ---------------- driver ----------------
  // kind: 0 = hit, 1 = clean miss, 2 = dirty miss
  task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input int kind, input logic chk, input logic [7:0] exp_d,
                           input logic [7:0] wb_a, input logic [7:0] wb_d,
                           input logic noise);
    int a0, w0, k, lat, fill_k;
    logic is_hit;
    lat    = (kind == 0) ? 2 : (kind == 1) ? 5 : 6;
    fill_k = (kind == 2) ? 3 : 2;
    is_hit = (kind == 0);
    @(negedge clock); #1;
    check("ready_before_req", int'(ready), 1);
    exp_q.push_back({chk, is_hit, exp_d, 4'(lat)});
    a0 = ack_cnt;
    w0 = wr_cnt;
    req = 1'b1; wren = w; address = a; data = d;
    req_cycle = cycle;
    k = 0;
    while (ack_cnt == a0 && k < 40) begin
      @(negedge clock); #1;
      k = cycle - req_cycle;
      if (noise && (k == 1 || (k == 2 && kind != 0))) begin
        req = 1'b1; wren = 1'b0; address = a ^ 8'h80;
      end else begin
        req = 1'b0;
      end
      if (kind == 2 && k == 2) begin
        check("wb_wren", int'(ram_wren), 1);
        check("wb_address", int'(ram_address), int'(wb_a));
        check("wb_data", int'(ram_data), int'(wb_d));
      end
      if (kind != 0 && k == fill_k) begin
        check("fill_address", int'(ram_address), int'(a));
        check("fill_no_wren", int'(ram_wren), 0);
      end
    end
    req = 1'b0;
    if (ack_cnt == a0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout got=none expected=ack addr=0x%0h", a);
      exp_q.delete();
    end
    check("ram_write_count", wr_cnt - w0, (kind == 2) ? 1 : 0);
  endtask

  task automatic check_counts(input int exp_hits, input int exp_misses);
    @(negedge clock); #1;
    check("hit_count", int'(hit_count), exp_hits);
    check("miss_count", int'(miss_count), exp_misses);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, w0;
    reset = 1'b1; req = 1'b0; wren = 1'b0; address = '0; data = '0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_ack", int'(ack), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_cache_out", int'(cache_out), 0);
    check("rst_ram_address", int'(ram_address), 0);
    check("rst_ram_data", int'(ram_data), 0);
    check("rst_ram_wren", int'(ram_wren), 0);
    check("rst_hit_count", int'(hit_count), 0);
    check("rst_miss_count", int'(miss_count), 0);
    reset = 1'b0;

    // w  addr   data   kind chk exp    wb_a   wb_d   noise
    do_access(0, 8'h05, 8'h00, 1, 1, 8'h15, 8'h00, 8'h00, 0);
    check_counts(0, 1);
    do_access(0, 8'h05, 8'h00, 0, 1, 8'h15, 8'h00, 8'h00, 0);
    check_counts(1, 1);
    do_access(1, 8'h09, 8'hAA, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    do_access(0, 8'h09, 8'h00, 0, 1, 8'hAA, 8'h00, 8'h00, 0);
    do_access(1, 8'h01, 8'h11, 1, 0, 8'h00, 8'h00, 8'h00, 0);
    do_access(1, 8'h05, 8'h55, 2, 0, 8'h00, 8'h09, 8'hAA, 0);
    do_access(0, 8'h01, 8'h00, 0, 1, 8'h11, 8'h00, 8'h00, 0);
    do_access(0, 8'h09, 8'h00, 2, 1, 8'hAA, 8'h05, 8'h55, 0);
    do_access(0, 8'h05, 8'h00, 2, 1, 8'h55, 8'h01, 8'h11, 0);
    do_access(0, 8'h02, 8'h00, 1, 1, 8'h12, 8'h00, 8'h00, 1);
    do_access(0, 8'h02, 8'h00, 0, 1, 8'h12, 8'h00, 8'h00, 1);
    check_counts(4, 7);

    // Reset while the fill of 0x03 is waiting on RAM.
    @(negedge clock); #1;
    a0 = ack_cnt;
    w0 = wr_cnt;
    req = 1'b1; wren = 1'b0; address = 8'h03; req_cycle = cycle;
    @(negedge clock); #1;
    req = 1'b0;
    @(negedge clock); #1;
    check("pre_reset_fill_address", int'(ram_address), 8'h03);
    reset = 1'b1;
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_ack", int'(ack), 0);
    check("abort_ram_wren", int'(ram_wren), 0);
    check("abort_hit_count", int'(hit_count), 0);
    check("abort_miss_count", int'(miss_count), 0);
    @(negedge clock); #1;
    reset = 1'b0;
    repeat (10) @(negedge clock);
    #1;
    check("abort_no_ack", ack_cnt - a0, 0);
    check("abort_no_ram_write", wr_cnt - w0, 0);

    do_access(0, 8'h03, 8'h00, 1, 1, 8'h13, 8'h00, 8'h00, 0);
    do_access(0, 8'h05, 8'h00, 1, 1, 8'h55, 8'h00, 8'h00, 0);
    check_counts(0, 2);

    for (int i = 0; i < 300; i++)
      do_access(0, 8'h05, 8'h00, 0, 1, 8'h55, 8'h00, 8'h00, 0);
    check_counts(255, 2);

    repeat (5) @(negedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog got=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-back, write-allocate cache controller placed between a requester (board switch/key logic or a small CPU) and the single-port RAM. It owns the tag/valid/dirty/LRU state and the cache data lines. It sequences every access: hit service, victim write-back and line fill. Each RAM access takes a fixed read latency. Hit and miss counters are exported for the seven-segment display logic.

## Interface
- `ADDR_W`, 8, byte address width; index = `address[1:0]`, tag = `address[ADDR_W-1:2]`
- `DATA_W`, 8, data word width; one word per line
- `RAM_LAT`, 2, cycles from RAM address presentation to valid `ram_out` (1..3)
- `clock` in 1: single clock, all state updates on its rising edge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `req` in 1: access request, sampled only when `ready`=1
- `wren` in 1: 1 = write, 0 = read; sampled with `req`
- `address` in ADDR_W: access address, sampled with `req`
- `data` in DATA_W: write data, sampled with `req`
- `ready` out 1: controller in IDLE, can accept `req`
- `ack` out 1: one-cycle pulse, access complete
- `hit` out 1: valid while `ack`=1; 1 = access hit
- `cache_out` out DATA_W: read data, valid from `ack` and held until next `ack`
- `ram_address` out ADDR_W: RAM address
- `ram_data` out DATA_W: RAM write data
- `ram_wren` out 1: RAM write enable
- `ram_out` in DATA_W: RAM read data
- `hit_count`, `miss_count` out 8 each: saturating counters

## Operation
- Storage: 4 sets × 2 ways. Each way holds a valid bit, a dirty bit, a tag and a data word. Each set holds one LRU bit, which names the way to evict.
- States: IDLE, COMPARE, WRITEBACK, FILL_WAIT, FILL, DONE.
- **IDLE** (`ready`=1):
  - On `req`, latch `wren`, `address` and `data`, then go to COMPARE.
  - `req` is ignored in every other state; the requester must re-issue.
- **COMPARE**, on a hit (valid and tag match in a way):
  - Read: `cache_out` = way data.
  - Write: way data = latched data, dirty = 1.
  - LRU = the other way. Go to DONE with `hit`=1.
- **COMPARE**, on a miss, select the victim:
  - First invalid way, with way0 preferred; if both ways are valid, the LRU way.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL_WAIT.
- **WRITEBACK**: exactly one cycle with `ram_wren`=1, `ram_address`={victim tag, index}, `ram_data`=victim data. Then go to FILL_WAIT.
- **FILL_WAIT**: `ram_address` = latched address, `ram_wren`=0. A counter runs RAM_LAT cycles, then goes to FILL.
- **FILL**:
  - Victim way gets tag, valid = 1, dirty = 0, data = `ram_out`.
  - On a write, data is overwritten with the latched data and dirty = 1.
  - On a read, `cache_out` = `ram_out`.
  - LRU = the other way. Go to DONE with `hit`=0.
- **DONE**: `ack`=1 for one cycle. `hit_count` or `miss_count` increments (holds at 255). Go to IDLE.
- Reset values: state IDLE, `ready`=1, `ack`=0, `hit`=0, `cache_out`=0, `ram_address`=0, `ram_data`=0, `ram_wren`=0, both counters 0, all valid/dirty/LRU = 0. Data and tag arrays need not be cleared.

## Timing
- `req` is sampled at edge 0. Latencies to the `ack` edge:
  - Hit: 2 cycles.
  - Clean miss: 3+RAM_LAT cycles (5 at default).
  - Dirty miss: 4+RAM_LAT cycles (6 at default).
- `ready` falls in the cycle after the `req` is sampled. It rises in the cycle after `ack`, so back-to-back requests are spaced by at least one idle cycle.
- `ram_wren` is never high outside WRITEBACK and is never high for 2 consecutive cycles.
- Reset mid-operation aborts the access:
  - No `ack` is produced, and no `ram_wren` is asserted after `reset` rises.
  - A write-back already completed stays in RAM. The aborted line remains invalid.
- Both counters saturate at 255, with no wrap.

## Test plan
- After reset, read 0x05 (RAM[0x05]=0x15) -> miss, `ram_address`=0x05, `ack` 5 cycles after `req`, `cache_out`=0x15, `miss_count`=1. Re-read 0x05 -> `hit`=1 at 2 cycles, `hit_count`=1, no RAM activity.
- Write 0xAA to 0x09 -> miss with fill and no `ram_wren`. Read 0x09 -> hit, `cache_out`=0xAA.
- Set 1 conflict:
  - Write 0x01=0x11, then write 0x05=0x55; read 0x01 (hit).
  - Read 0x09 -> evicts 0x05: one cycle with `ram_wren`=1, `ram_address`=0x05, `ram_data`=0x55.
  - Then fill from 0x09; `ack` at 6 cycles.
- Assert `reset` during FILL_WAIT -> `ack` never pulses and `ready`=1 immediately. Re-read the same address -> miss.
- Pulse `req` while the controller is in COMPARE or FILL_WAIT -> ignored, exactly one `ack` per accepted request.
- 300 hits to 0x05 -> `hit_count` holds at 255.
